// File: rtl/gemm_inst_sequencer.sv
// Instruction sequencer for a GEMM engine: fetches from a local instruction memory and issues LD/ST commands and GEMM/DRAIN phases.
// Define SEQ_PERF_COUNTERS_EN to build the saturating perf_cycles/perf_insts counters; otherwise both read as 0.
module gemm_inst_sequencer #(
    parameter int INST_WIDTH      = 16,
    parameter int OPCODE_WIDTH    = 4,
    parameter int BUF_ID_WIDTH    = 2,
    parameter int MEM_LOC_WIDTH   = 10,
    parameter int LOG2_IMEM_DEPTH = 10,
    parameter int CTRL_WIDTH      = 4,
    parameter int GEMM_CYCLES     = 11,
    parameter int DRAIN_CYCLES    = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       imem_wr_en,
    input  logic [LOG2_IMEM_DEPTH-1:0] imem_wr_addr,
    input  logic [INST_WIDTH-1:0]      imem_wr_data,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [OPCODE_WIDTH-1:0]    cmd_opcode,
    output logic [BUF_ID_WIDTH-1:0]    cmd_buf_id,
    output logic [MEM_LOC_WIDTH-1:0]   cmd_mem_loc,
    input  logic                       cmd_done,
    output logic [CTRL_WIDTH-1:0]      ctrl_state,
    output logic [LOG2_IMEM_DEPTH-1:0] pc,
    output logic                       busy,
    output logic                       done,
    output logic                       illegal_op,
    output logic [31:0]                perf_cycles,
    output logic [31:0]                perf_insts
);
    localparam int IMEM_DEPTH = 2 ** LOG2_IMEM_DEPTH;
    localparam int CNT_WIDTH  = 16;

    localparam logic [OPCODE_WIDTH-1:0] OP_LD    = OPCODE_WIDTH'(4'b0010);
    localparam logic [OPCODE_WIDTH-1:0] OP_ST    = OPCODE_WIDTH'(4'b0011);
    localparam logic [OPCODE_WIDTH-1:0] OP_GEMM  = OPCODE_WIDTH'(4'b0100);
    localparam logic [OPCODE_WIDTH-1:0] OP_DRAIN = OPCODE_WIDTH'(4'b0101);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(4'b1111);

    localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE   = CTRL_WIDTH'(0);
    localparam logic [CTRL_WIDTH-1:0] CTRL_STEADY = CTRL_WIDTH'(1);
    localparam logic [CTRL_WIDTH-1:0] CTRL_DRAIN  = CTRL_WIDTH'(2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_GEMM   = 3'd5;
    localparam logic [2:0] S_DRAIN  = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    logic [INST_WIDTH-1:0]      r_imem [IMEM_DEPTH];
    logic [INST_WIDTH-1:0]      r_inst;
    logic [2:0]                 r_state;
    logic [CNT_WIDTH-1:0]       r_phase_cnt;
    logic                       r_cmd_valid;
    logic [OPCODE_WIDTH-1:0]    r_cmd_opcode;
    logic [BUF_ID_WIDTH-1:0]    r_cmd_buf_id;
    logic [MEM_LOC_WIDTH-1:0]   r_cmd_mem_loc;
    logic [CTRL_WIDTH-1:0]      r_ctrl_state;
    logic [LOG2_IMEM_DEPTH-1:0] r_pc;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_illegal;

    logic [OPCODE_WIDTH-1:0]    w_opcode;
    logic [BUF_ID_WIDTH-1:0]    w_buf_id;
    logic [MEM_LOC_WIDTH-1:0]   w_mem_loc;
    logic                       w_start_acc;
    logic                       w_retire;

    assign w_opcode    = r_inst[INST_WIDTH-1 -: OPCODE_WIDTH];
    assign w_buf_id    = r_inst[INST_WIDTH-OPCODE_WIDTH-1 -: BUF_ID_WIDTH];
    assign w_mem_loc   = r_inst[MEM_LOC_WIDTH-1:0];
    assign w_start_acc = (r_state == S_IDLE) && start;

    // NOTE: the instruction store is deliberately left out of reset so a program survives rst_n.
    // Reading every cycle with non-blocking writes gives old data on a same-address write.
    always_ff @(posedge clk) begin
        if (imem_wr_en) begin
            r_imem[imem_wr_addr] <= imem_wr_data;
        end
        r_inst <= r_imem[r_pc];
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_DECODE: w_retire = !(w_opcode inside {OP_LD, OP_ST, OP_GEMM, OP_DRAIN, OP_HALT});
            S_WAIT:   w_retire = cmd_done;
            S_GEMM:   w_retire = (r_phase_cnt == CNT_WIDTH'(GEMM_CYCLES - 1));
            S_DRAIN:  w_retire = (r_phase_cnt == CNT_WIDTH'(DRAIN_CYCLES - 1));
            default:  w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_phase_cnt   <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_opcode  <= '0;
            r_cmd_buf_id  <= '0;
            r_cmd_mem_loc <= '0;
            r_ctrl_state  <= CTRL_IDLE;
            r_pc          <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_acc) begin
                        r_pc      <= '0;
                        r_busy    <= 1'b1;
                        r_illegal <= 1'b0;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    case (w_opcode)
                        OP_LD, OP_ST: begin
                            r_cmd_valid   <= 1'b1;
                            r_cmd_opcode  <= w_opcode;
                            r_cmd_buf_id  <= w_buf_id;
                            r_cmd_mem_loc <= w_mem_loc;
                            r_state       <= S_ISSUE;
                        end
                        OP_GEMM: begin
                            r_ctrl_state <= CTRL_STEADY;
                            r_phase_cnt  <= '0;
                            r_state      <= S_GEMM;
                        end
                        OP_DRAIN: begin
                            r_ctrl_state <= CTRL_DRAIN;
                            r_phase_cnt  <= '0;
                            r_state      <= S_DRAIN;
                        end
                        OP_HALT: begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_HALT;
                        end
                        default: r_illegal <= 1'b1;
                    endcase
                end
                S_ISSUE: begin
                    // cmd_done is not looked at here, so one coinciding with the handshake is dropped.
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: ;
                S_GEMM, S_DRAIN: begin
                    if (w_retire) begin
                        r_ctrl_state <= CTRL_IDLE;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + CNT_WIDTH'(1);
                    end
                end
                S_HALT:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_retire) begin
                r_pc    <= r_pc + LOG2_IMEM_DEPTH'(1);
                r_state <= S_FETCH;
            end
        end
    end

`ifdef SEQ_PERF_COUNTERS_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_insts;
    logic        w_inst_done;

    assign w_inst_done = w_retire || ((r_state == S_DECODE) && (w_opcode == OP_HALT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cycles <= '0;
            r_perf_insts  <= '0;
        end else begin
            if (w_start_acc) begin
                r_perf_cycles <= '0;
            end else if (r_busy && (r_perf_cycles != '1)) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (w_inst_done && (r_perf_insts != '1)) begin
                r_perf_insts <= r_perf_insts + 32'd1;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_insts  = r_perf_insts;
`else
    assign perf_cycles = '0;
    assign perf_insts  = '0;
`endif

    assign cmd_valid   = r_cmd_valid;
    assign cmd_opcode  = r_cmd_opcode;
    assign cmd_buf_id  = r_cmd_buf_id;
    assign cmd_mem_loc = r_cmd_mem_loc;
    assign ctrl_state  = r_ctrl_state;
    assign pc          = r_pc;
    assign busy        = r_busy;
    assign done        = r_done;
    assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_gemm_inst_sequencer.sv
// Scoreboard bench for gemm_inst_sequencer: an instruction-level program model predicts commands, ctrl phases and done.
// Perf-counter expectations follow SEQ_PERF_COUNTERS_EN (counts when defined, zero otherwise).
module tb_gemm_inst_sequencer;
    localparam int OP_LD = 2, OP_ST = 3, OP_GEMM = 4, OP_DRAIN = 5, OP_HALT = 15;
    localparam int N_GEMM = 11, N_DRAIN = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_wr_en;
    logic [9:0]  imem_wr_addr;
    logic [15:0] imem_wr_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [1:0]  cmd_buf_id;
    logic [9:0]  cmd_mem_loc;
    logic        cmd_done;
    logic [3:0]  ctrl_state;
    logic [9:0]  pc;
    logic        busy;
    logic        done;
    logic        illegal_op;
    logic [31:0] perf_cycles;
    logic [31:0] perf_insts;

    gemm_inst_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_buf_id(cmd_buf_id), .cmd_mem_loc(cmd_mem_loc), .cmd_done(cmd_done),
        .ctrl_state(ctrl_state), .pc(pc), .busy(busy), .done(done), .illegal_op(illegal_op),
        .perf_cycles(perf_cycles), .perf_insts(perf_insts)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int pc; int op; int buf_id; int loc; int vlen; } cmd_exp_t;
    typedef struct { int st; int len; } run_exp_t;
    typedef struct { int pc; bit ill; int insts; } done_exp_t;

    cmd_exp_t  exp_cmd[$];
    run_exp_t  exp_run[$];
    done_exp_t exp_done[$];
    int        rdy_q[$];
    int        dn_q[$];
    bit        glt_q[$];

    logic [15:0] mem_img [1024];
    int  n_vec = 0, n_err = 0;
    int  done_count = 0;
    int  start_cyc = 0;
    int  model_insts = 0;
    bit  rnd_resp = 0;
    int  fix_rd = 0, fix_dd = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int b, input int loc);
        return {op[3:0], b[1:0], loc[9:0]};
    endfunction

    // Walks the program as an instruction list and records what the block must present, in order.
    function automatic void model_run(input bit first_is_gemm);
        int  mpc = 0;
        bit  ill = 0;
        for (int step = 0; step < 4096; step++) begin
            logic [15:0] w = (step == 0 && first_is_gemm) ? enc(OP_GEMM, 0, 0) : mem_img[mpc];
            int op = int'(w[15:12]);
            model_insts++;
            if (op == OP_LD || op == OP_ST) begin
                int rd = rnd_resp ? int'($urandom_range(0, 4)) : fix_rd;
                int dd = rnd_resp ? int'($urandom_range(1, 6)) : fix_dd;
                exp_cmd.push_back('{mpc, op, int'(w[11:10]), int'(w[9:0]), rd + 1});
                rdy_q.push_back(rd);
                dn_q.push_back(dd);
                glt_q.push_back(rnd_resp && ($urandom_range(0, 2) == 0));
            end else if (op == OP_GEMM) begin
                exp_run.push_back('{1, N_GEMM});
            end else if (op == OP_DRAIN) begin
                exp_run.push_back('{2, N_DRAIN});
            end else if (op == OP_HALT) begin
                exp_done.push_back('{mpc, ill, model_insts});
                return;
            end else begin
                ill = 1;
            end
            mpc = (mpc + 1) % 1024;
        end
    endfunction

    task automatic load(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            @(negedge clk);
            imem_wr_en   = 1'b1;
            imem_wr_addr = 10'(a);
            imem_wr_data = mem_img[a];
        end
        @(negedge clk);
        imem_wr_en = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int t = 0;
        while (done_count < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("done_within_budget", done_count >= target, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_program(input bit wr0_halt, input bit extra_start, input int budget);
        int target = done_count + 1;
        model_run(wr0_halt);
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        if (wr0_halt) begin
            // Overwrites address 0 in the very cycle it is being fetched.
            imem_wr_en   = 1'b1;
            imem_wr_addr = '0;
            imem_wr_data = enc(OP_HALT, 0, 0);
        end
        @(negedge clk);
        imem_wr_en = 1'b0;
        if (extra_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(target, budget);
    endtask

    // Command responder: ready/done delays come from the queues filled alongside the expectations.
    initial begin
        cmd_ready = 1'b0;
        cmd_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && cmd_valid === 1'b1) begin
                int rd, dd;
                bit gl, bad;
                rd = (rdy_q.size() > 0) ? rdy_q.pop_front() : 0;
                dd = (dn_q.size() > 0) ? dn_q.pop_front() : 1;
                gl = (glt_q.size() > 0) ? glt_q.pop_front() : 1'b0;
                repeat (rd) @(negedge clk);
                cmd_ready = 1'b1;
                cmd_done  = gl;
                @(negedge clk);
                cmd_ready = 1'b0;
                cmd_done  = 1'b0;
                bad = 1'b0;
                for (int i = 1; i < dd; i++) begin
                    bad |= cmd_valid;
                    @(negedge clk);
                end
                bad |= cmd_valid;
                check("no_issue_before_cmd_done", bad, 0);
                cmd_done = 1'b1;
                @(negedge clk);
                cmd_done = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a handshake, a finished ctrl phase or done.
    initial begin
        bit          pend = 0, prev_done = 0;
        int          vlen = 0, prev_st = 0, run_len = 0, cur;
        logic [15:0] held;
        cmd_exp_t    ce;
        run_exp_t    re;
        done_exp_t   de;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                pend = 0; prev_st = 0; run_len = 0; prev_done = 0;
                continue;
            end
            if (cmd_valid) begin
                if (!pend) begin
                    pend = 1; vlen = 1;
                    held = {cmd_opcode, cmd_buf_id, cmd_mem_loc};
                end else begin
                    vlen++;
                    check("cmd_fields_stable", {cmd_opcode, cmd_buf_id, cmd_mem_loc}, held);
                end
                if (cmd_ready) begin
                    pend = 0;
                    check("cmd_expected", exp_cmd.size() > 0, 1);
                    if (exp_cmd.size() > 0) begin
                        ce = exp_cmd.pop_front();
                        check("cmd_pc", pc, ce.pc);
                        check("cmd_opcode", cmd_opcode, ce.op);
                        check("cmd_buf_id", cmd_buf_id, ce.buf_id);
                        check("cmd_mem_loc", cmd_mem_loc, ce.loc);
                        check("cmd_valid_cycles", vlen, ce.vlen);
                    end
                end
            end
            cur = int'(ctrl_state);
            if (cur == prev_st && cur != 0) begin
                run_len++;
            end else begin
                if (prev_st != 0) begin
                    check("ctrl_expected", exp_run.size() > 0, 1);
                    if (exp_run.size() > 0) begin
                        re = exp_run.pop_front();
                        check("ctrl_state_value", prev_st, re.st);
                        check("ctrl_state_cycles", run_len, re.len);
                    end
                end
                run_len = (cur != 0) ? 1 : 0;
            end
            prev_st = cur;
            if (done) begin
                check("done_single_cycle", prev_done, 0);
                check("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    de = exp_done.pop_front();
                    check("done_pc", pc, de.pc);
                    check("done_illegal_op", illegal_op, de.ill);
                    check("done_busy_cleared", busy, 0);
`ifdef SEQ_PERF_COUNTERS_EN
                    check("perf_insts", perf_insts, de.insts);
                    check("perf_cycles", perf_cycles, cyc - start_cyc - 1);
`else
                    check("perf_insts_tied", perf_insts, 0);
                    check("perf_cycles_tied", perf_cycles, 0);
`endif
                end
                done_count++;
            end
            prev_done = done;
        end
    end

    initial begin
        int len, op, t;
        rst_n = 1'b0; start = 1'b0;
        imem_wr_en = 1'b0; imem_wr_addr = '0; imem_wr_data = '0;
        #1;
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_ctrl_state", ctrl_state, 0);
        check("rst_pc", pc, 0);
        check("rst_busy_done_illegal", {busy, done, illegal_op}, 0);
        check("rst_cmd_fields", {cmd_opcode, cmd_buf_id, cmd_mem_loc}, 0);
        check("rst_perf", {perf_cycles, perf_insts}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // LD then HALT with immediate ready and cmd_done three cycles after the handshake.
        mem_img[0] = enc(OP_LD, 0, 5);
        mem_img[1] = enc(OP_HALT, 0, 0);
        load(0, 1);
        rnd_resp = 0; fix_rd = 0; fix_dd = 3;
        run_program(0, 0, 500);

        // ST held off by seven cycles of cmd_ready low.
        mem_img[0] = enc(OP_ST, 2, 'h3A5);
        load(0, 0);
        fix_rd = 7; fix_dd = 2;
        run_program(0, 0, 500);

        mem_img[0] = enc(OP_GEMM, 0, 0);
        mem_img[1] = enc(OP_DRAIN, 0, 0);
        mem_img[2] = enc(OP_HALT, 0, 0);
        load(0, 2);
        run_program(0, 0, 500);

        // Unknown opcode: sticky until the next accepted start.
        mem_img[0] = enc(8, 1, 77);
        mem_img[1] = enc(OP_HALT, 0, 0);
        load(0, 1);
        run_program(0, 0, 500);
        repeat (3) @(negedge clk);
        check("illegal_sticky_after_done", illegal_op, 1);
        mem_img[0] = enc(OP_HALT, 0, 0);
        load(0, 0);
        run_program(0, 0, 500);

        // Random programs with random handshake timing and a stray start while busy.
        rnd_resp = 1;
        for (int p = 0; p < 25; p++) begin
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 4))
                    0: op = OP_LD;
                    1: op = OP_ST;
                    2: op = OP_GEMM;
                    3: op = OP_DRAIN;
                    default: begin
                        op = int'($urandom_range(0, 14));
                        while (op >= OP_LD && op <= OP_DRAIN) op = int'($urandom_range(0, 14));
                    end
                endcase
                mem_img[i] = enc(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)));
            end
            mem_img[len] = enc(OP_HALT, 0, 0);
            load(0, len);
            run_program(0, p[0], 3000);
        end
        rnd_resp = 0;

        // Reset in the middle of a GEMM phase, then rerun the untouched program.
        mem_img[0] = enc(OP_GEMM, 0, 0);
        mem_img[1] = enc(OP_HALT, 0, 0);
        load(0, 1);
        model_run(0);
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (ctrl_state !== 4'd1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("gemm_phase_reached", ctrl_state, 1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ctrl_state", ctrl_state, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_cmd_valid", cmd_valid, 0);
        check("async_rst_pc", pc, 0);
        exp_cmd.delete(); exp_run.delete(); exp_done.delete();
        rdy_q.delete(); dn_q.delete(); glt_q.delete();
        model_insts = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_program(0, 0, 500);

        // Whole memory of GEMM; address 0 becomes HALT while it is being fetched, so pc must wrap to reach it.
        for (int a = 0; a < 1024; a++) mem_img[a] = enc(OP_GEMM, 0, 0);
        load(0, 1023);
        mem_img[0] = enc(OP_HALT, 0, 0);
        run_program(1, 0, 20000);

        repeat (5) @(negedge clk);
        check("leftover_expectations", exp_cmd.size() + exp_run.size() + exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
